// File: rtl/iiitb_bm_prod_acc_if.sv
// Product-accumulator bus: product stream in, accumulated sum out with a
// valid/ready handshake, plus the clear and flush controls.
interface iiitb_bm_prod_acc_if #(
    parameter int ACC_W = 12
) ();
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_p;
    logic             flush;
    logic             sum_valid;
    logic             sum_ready;
    logic [ACC_W-1:0] sum;
    logic [7:0]       sum_cnt;
    logic             sum_ovf;

    // Producer/consumer side
    modport master (
        output clear, in_valid, in_p, flush, sum_ready,
        input  in_ready, sum_valid, sum, sum_cnt, sum_ovf
    );

    // Accumulator side
    modport slave (
        input  clear, in_valid, in_p, flush, sum_ready,
        output in_ready, sum_valid, sum, sum_cnt, sum_ovf
    );
endinterface

// File: rtl/iiitb_bm_prod_acc.sv
// Accumulation stage for the Booth multiplier product stream.
// Sums BURST signed 8-bit products (or fewer, when flushed) into an ACC_W-bit
// accumulator and holds each completed sum until the consumer takes it.
// Optional feature: define IIITB_BM_ACC_SAT_EN to saturate the accumulator on
// signed overflow instead of wrapping. The overflow flag is set either way.
module iiitb_bm_prod_acc #(
    parameter int ACC_W = 12,
    parameter int BURST = 4
) (
    input logic                 clk,
    input logic                 reset,
    iiitb_bm_prod_acc_if.slave  bus
);
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(BURST - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             sum_valid_q, sum_valid_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [7:0]       sum_cnt_q, sum_cnt_d;
    logic             sum_ovf_q, sum_ovf_d;

    logic             beat_s;
    logic [ACC_W:0]   ext_s;
    logic             step_ovf_s;
    logic [ACC_W-1:0] acc_step_s;

`ifdef IIITB_BM_ACC_SAT_EN
    // Clamp value for an overflowed sum; neg is the sign of the true sum.
    function automatic logic [ACC_W-1:0] sat_value(input logic neg);
        return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction
`endif

    assign beat_s     = bus.in_valid && (state_q == ST_ACCUM);
    // One guard bit: the top two bits of the widened sum differ on overflow,
    // and the top bit is the sign of the true sum.
    assign ext_s      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){bus.in_p[7]}}, bus.in_p};
    assign step_ovf_s = ext_s[ACC_W] ^ ext_s[ACC_W-1];

`ifdef IIITB_BM_ACC_SAT_EN
    assign acc_step_s = step_ovf_s ? sat_value(ext_s[ACC_W]) : ext_s[ACC_W-1:0];
`else
    assign acc_step_s = ext_s[ACC_W-1:0];
`endif

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.sum_valid = sum_valid_q;
    assign bus.sum       = sum_q;
    assign bus.sum_cnt   = sum_cnt_q;
    assign bus.sum_ovf   = sum_ovf_q;

    // Next-state logic: accumulate beats, close bursts, release on handshake.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_valid_d = sum_valid_q;
        sum_d       = sum_q;
        sum_cnt_d   = sum_cnt_q;
        sum_ovf_d   = sum_ovf_q;
        if (bus.clear) begin
            state_d     = ST_ACCUM;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = 8'd0;
            ovf_d       = 1'b0;
            sum_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (beat_s) begin
                        acc_d = acc_step_s;
                        cnt_d = cnt_q + 8'd1;
                        ovf_d = ovf_q | step_ovf_s;
                    end else begin
                        acc_d = acc_q;
                    end
                    // The closing beat, if any, is already folded into acc_d/cnt_d/ovf_d.
                    if ((beat_s && (cnt_q == LAST_CNT)) ||
                        (bus.flush && ((cnt_q != 8'd0) || beat_s))) begin
                        state_d     = ST_HOLD;
                        sum_valid_d = 1'b1;
                        sum_d       = acc_d;
                        sum_cnt_d   = cnt_d;
                        sum_ovf_d   = ovf_d;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (bus.sum_ready) begin
                        state_d     = ST_ACCUM;
                        acc_d       = {ACC_W{1'b0}};
                        cnt_d       = 8'd0;
                        ovf_d       = 1'b0;
                        sum_valid_d = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d     = ST_ACCUM;
                    acc_d       = {ACC_W{1'b0}};
                    cnt_d       = 8'd0;
                    ovf_d       = 1'b0;
                    sum_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ACCUM;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= 8'd0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
            sum_q       <= {ACC_W{1'b0}};
            sum_cnt_q   <= 8'd0;
            sum_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sum_valid_q <= sum_valid_d;
            sum_q       <= sum_d;
            sum_cnt_q   <= sum_cnt_d;
            sum_ovf_q   <= sum_ovf_d;
        end
    end
endmodule
